// File: rtl/conv_array_pkg.sv
// Shared types, defaults and width helpers for the conv_array convolution engine.
package conv_array_pkg;

  localparam int DEF_N_CH    = 8;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_K       = 3;
  localparam int DEF_ROW_MAX = 256;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_FILT,
    ST_FILL,
    ST_RUN,
    ST_DRAIN
  } state_e;

  // Index width that never collapses to zero bits for single-entry ranges.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of one channel's K x K dot product at full precision.
  function automatic int mac_w(input int data_w, input int k);
    return 2 * data_w + idx_w(k * k);
  endfunction

endpackage

// File: rtl/convolver_ch.sv
// One input channel of conv_array: K-1 row line buffers, a K x K sliding window,
// the channel's coefficient store and a registered MAC over the window.
module convolver_ch
  import conv_array_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int K       = DEF_K,
  parameter int ROW_MAX = DEF_ROW_MAX,
  parameter int COL_W   = idx_w(ROW_MAX),
  parameter int CI_W    = idx_w(K * K),
  parameter int MAC_W   = mac_w(DATA_W, K)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     coef_we,
  input  logic [CI_W-1:0]          coef_idx,
  input  logic signed [DATA_W-1:0] coef_in,
  input  logic                     pix_we,
  input  logic [COL_W-1:0]         col,
  input  logic signed [DATA_W-1:0] pix_in,
  input  logic                     adv,
  output logic signed [MAC_W-1:0]  mac_out
);

  localparam int LB_N = (K > 1) ? K - 1 : 1;

  logic signed [DATA_W-1:0] lb_q   [LB_N][ROW_MAX];
  logic signed [DATA_W-1:0] lb_d   [LB_N][ROW_MAX];
  logic signed [DATA_W-1:0] win_q  [K][K];
  logic signed [DATA_W-1:0] win_d  [K][K];
  logic signed [DATA_W-1:0] coef_q [K*K];
  logic signed [DATA_W-1:0] coef_d [K*K];
  logic signed [MAC_W-1:0]  mac_q, mac_d;

  // NOTE: each always_comb starts from the held value of every target, so no path can infer a latch.
  always_comb begin
    lb_d   = lb_q;
    win_d  = win_q;
    coef_d = coef_q;
    if (coef_we) coef_d[coef_idx] = coef_in;
    if (pix_we) begin
      // Slide left; the new right column is the pixel stacked under its line-buffer history.
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K - 1; c++)
          win_d[r][c] = win_q[r][c+1];
      for (int r = 0; r < K - 1; r++)
        win_d[r][K-1] = lb_q[K-2-r][col];
      win_d[K-1][K-1] = pix_in;
      lb_d[0][col] = pix_in;
      for (int j = 1; j < K - 1; j++)
        lb_d[j][col] = lb_q[j-1][col];
    end
  end

  always_comb begin
    mac_d = mac_q;
    if (adv) begin
      mac_d = '0;
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++)
          mac_d += MAC_W'(win_q[r][c]) * MAC_W'(coef_q[r*K+c]);
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  // NOTE: the line buffers are on the async reset as well, so reset leaves no stale pixels behind.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lb_q   <= '{default: '0};
      win_q  <= '{default: '0};
      coef_q <= '{default: '0};
      mac_q  <= '0;
    end else begin
      lb_q   <= lb_d;
      win_q  <= win_d;
      coef_q <= coef_d;
      mac_q  <= mac_d;
    end
  end

  assign mac_out = mac_q;

endmodule

// File: rtl/conv_array.sv
// Multi-channel K x K streaming convolver: frame FSM, raster counters, handshakes
// and the registered cross-channel adder tree. Define CONV_ARRAY_RELU_EN to clamp sums at zero.
module conv_array
  import conv_array_pkg::*;
#(
  parameter int N_CH    = DEF_N_CH,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int K       = DEF_K,
  parameter int ROW_MAX = DEF_ROW_MAX,
  parameter int ACC_W   = 2 * DATA_W + $clog2(K * K * N_CH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [$clog2(ROW_MAX+1)-1:0]   cfg_row_length,
  input  logic [15:0]                    cfg_num_rows,
  input  logic                           start,
  output logic                           busy,
  output logic                           done,
  output logic                           cfg_err,
  input  logic                           filt_valid,
  output logic                           filt_ready,
  input  logic [N_CH*DATA_W-1:0]         filt_data,
  input  logic                           pix_valid,
  output logic                           pix_ready,
  input  logic [N_CH*DATA_W-1:0]         pix_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [ACC_W-1:0]        out_data
);

  localparam int LEN_W = $clog2(ROW_MAX + 1);
  localparam int COL_W = idx_w(ROW_MAX);
  localparam int CI_W  = idx_w(K * K);
  localparam int MAC_W = mac_w(DATA_W, K);

  state_e                  state_q, state_d;
  logic [LEN_W-1:0]        row_len_q, row_len_d;
  logic [15:0]             num_rows_q, num_rows_d;
  logic [15:0]             row_q, row_d;
  logic [COL_W-1:0]        col_q, col_d;
  logic [CI_W-1:0]         fcnt_q, fcnt_d;
  logic                    cfg_err_q, cfg_err_d;
  logic                    done_q, done_d;
  logic                    v0_q, v0_d, v1_q, v1_d;
  logic                    out_valid_q, out_valid_d;
  logic signed [ACC_W-1:0] out_data_q, out_data_d;
  logic signed [ACC_W-1:0] sum, res;
  logic signed [MAC_W-1:0] mac [N_CH];
  logic adv, filt_acc, pix_acc, cfg_ok, col_last, row_last, run_prod;

  // A held output freezes every pipeline stage, including pixel intake.
  assign adv        = !out_valid_q || out_ready;
  assign filt_ready = (state_q == ST_LOAD_FILT);
  assign pix_ready  = ((state_q == ST_FILL) || (state_q == ST_RUN)) && adv;
  assign filt_acc   = filt_valid && filt_ready;
  assign pix_acc    = pix_valid && pix_ready;

  assign cfg_ok   = (cfg_row_length >= LEN_W'(K)) && (cfg_row_length <= LEN_W'(ROW_MAX))
                 && (cfg_num_rows >= 16'(K));
  assign col_last = (LEN_W'(col_q) == row_len_q - LEN_W'(1));
  assign row_last = (row_q == num_rows_q - 16'd1);
  assign run_prod = (state_q == ST_RUN) && (col_q >= COL_W'(K - 1));

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    convolver_ch #(
      .DATA_W  (DATA_W),
      .K       (K),
      .ROW_MAX (ROW_MAX),
      .COL_W   (COL_W),
      .CI_W    (CI_W),
      .MAC_W   (MAC_W)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .coef_we  (filt_acc),
      .coef_idx (fcnt_q),
      .coef_in  (filt_data[ch*DATA_W +: DATA_W]),
      .pix_we   (pix_acc),
      .col      (col_q),
      .pix_in   (pix_data[ch*DATA_W +: DATA_W]),
      .adv      (adv),
      .mac_out  (mac[ch])
    );
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < N_CH; i++) sum += ACC_W'(mac[i]);
`ifdef CONV_ARRAY_RELU_EN
    res = sum[ACC_W-1] ? '0 : sum;
`else
    res = sum;
`endif
  end

  always_comb begin
    state_d    = state_q;
    row_len_d  = row_len_q;
    num_rows_d = num_rows_q;
    row_d      = row_q;
    col_d      = col_q;
    fcnt_d     = fcnt_q;
    cfg_err_d  = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            state_d    = ST_LOAD_FILT;
            row_len_d  = cfg_row_length;
            num_rows_d = cfg_num_rows;
            row_d      = '0;
            col_d      = '0;
            fcnt_d     = '0;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      ST_LOAD_FILT: begin
        if (filt_acc) begin
          if (fcnt_q == CI_W'(K * K - 1)) begin
            fcnt_d  = '0;
            state_d = (K > 1) ? ST_FILL : ST_RUN;
          end else begin
            fcnt_d = fcnt_q + CI_W'(1);
          end
        end
      end
      ST_FILL, ST_RUN: begin
        if (pix_acc) begin
          if (col_last) begin
            col_d = '0;
            row_d = row_q + 16'd1;
          end else begin
            col_d = col_q + COL_W'(1);
          end
          // The first window-completing pixel sits at (K-1, K-1), so filling ends one pixel before it.
          if ((state_q == ST_FILL) && (row_q == 16'(K - 1)) && (col_q == COL_W'(K - 2)))
            state_d = ST_RUN;
          if ((state_q == ST_RUN) && row_last && col_last)
            state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!v0_q && !v1_q && out_valid_q && out_ready) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    v0_d        = v0_q;
    v1_d        = v1_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (adv) begin
      v0_d        = pix_acc && run_prod;
      v1_d        = v0_q;
      out_valid_d = v1_q;
      out_data_d  = res;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      row_len_q   <= '0;
      num_rows_q  <= '0;
      row_q       <= '0;
      col_q       <= '0;
      fcnt_q      <= '0;
      cfg_err_q   <= 1'b0;
      done_q      <= 1'b0;
      v0_q        <= 1'b0;
      v1_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      row_len_q   <= row_len_d;
      num_rows_q  <= num_rows_d;
      row_q       <= row_d;
      col_q       <= col_d;
      fcnt_q      <= fcnt_d;
      cfg_err_q   <= cfg_err_d;
      done_q      <= done_d;
      v0_q        <= v0_d;
      v1_q        <= v1_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign cfg_err   = cfg_err_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_conv_array.sv
// Directed self-checking bench for conv_array (N_CH=2, K=3): config rejection,
// full frames with hand-computed sums, output backpressure and mid-frame reset.
module tb_conv_array;

  localparam int N_CH    = 2;
  localparam int DATA_W  = 8;
  localparam int K       = 3;
  localparam int ROW_MAX = 256;
  localparam int ACC_W   = 2 * DATA_W + $clog2(K * K * N_CH);
  localparam int LEN_W   = $clog2(ROW_MAX + 1);
  localparam int BW      = N_CH * DATA_W;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [LEN_W-1:0]        cfg_row_length;
  logic [15:0]             cfg_num_rows;
  logic                    start;
  logic                    busy, done, cfg_err;
  logic                    filt_valid, filt_ready;
  logic [BW-1:0]           filt_data;
  logic                    pix_valid, pix_ready;
  logic [BW-1:0]           pix_data;
  logic                    out_valid, out_ready;
  logic signed [ACC_W-1:0] out_data;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [BW-1:0]           coef_beats [K*K];
  logic [BW-1:0]           pix_beats  [$];
  int                      exp_q      [$];
  logic signed [ACC_W-1:0] got_q      [$];
  int                      hs_cyc, done_cyc, stall_hits;
  bit                      done_seen;

  conv_array #(
    .N_CH    (N_CH),
    .DATA_W  (DATA_W),
    .K       (K),
    .ROW_MAX (ROW_MAX)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_row_length (cfg_row_length),
    .cfg_num_rows   (cfg_num_rows),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .cfg_err        (cfg_err),
    .filt_valid     (filt_valid),
    .filt_ready     (filt_ready),
    .filt_data      (filt_data),
    .pix_valid      (pix_valid),
    .pix_ready      (pix_ready),
    .pix_data       (pix_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"},       busy,       0);
    check({tag, "_done"},       done,       0);
    check({tag, "_cfg_err"},    cfg_err,    0);
    check({tag, "_filt_ready"}, filt_ready, 0);
    check({tag, "_pix_ready"},  pix_ready,  0);
    check({tag, "_out_valid"},  out_valid,  0);
    check({tag, "_out_data"},   out_data,   0);
  endtask

  task automatic pulse_start(input int rl, input int nr);
    @(posedge clk); #1;
    cfg_row_length = LEN_W'(rl);
    cfg_num_rows   = 16'(nr);
    start          = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic load_filters();
    int w;
    @(posedge clk); #1;
    for (int b = 0; b < K * K; b++) begin
      filt_valid = 1'b1;
      filt_data  = coef_beats[b];
      w = 0;
      @(negedge clk);
      while (!filt_ready && w < 100) begin
        @(negedge clk);
        w++;
      end
      check("filt_handshake", filt_ready, 1);
      if (!filt_ready) begin
        filt_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    filt_valid = 1'b0;
    @(negedge clk);
    check("filt_ready_after_load", filt_ready, 0);
  endtask

  task automatic drive_pixels(input int n);
    int w;
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      pix_valid = 1'b1;
      pix_data  = pix_beats[i];
      w = 0;
      @(negedge clk);
      while (!pix_ready && w < 200) begin
        @(negedge clk);
        w++;
      end
      if (!pix_ready) begin
        check("pix_handshake", pix_ready, 1);
        pix_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    pix_valid = 1'b0;
  endtask

  task automatic collect(input int stall_after);
    int  stall_left;
    bit  stalled, hold_valid;
    logic signed [ACC_W-1:0] held;
    got_q.delete();
    done_seen  = 1'b0;
    stalled    = 1'b0;
    hold_valid = 1'b0;
    stall_left = 0;
    stall_hits = 0;
    held       = '0;
    for (int t = 0; t < 3000 && !done_seen; t++) begin
      @(posedge clk); #1;
      if (!stalled && stall_after >= 0 && got_q.size() == stall_after) begin
        stalled    = 1'b1;
        stall_left = 10;
      end
      out_ready = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      @(negedge clk);
      if (done) begin
        done_seen = 1'b1;
        done_cyc  = cyc;
      end
      if (out_valid && out_ready) begin
        got_q.push_back(out_data);
        hs_cyc     = cyc;
        hold_valid = 1'b0;
      end else if (out_valid && !out_ready) begin
        stall_hits++;
        check("stall_pix_ready", pix_ready, 0);
        if (hold_valid) check("stall_hold_data", out_data, held);
        held       = out_data;
        hold_valid = 1'b1;
      end else begin
        hold_valid = 1'b0;
      end
    end
    out_ready = 1'b1;
  endtask

  task automatic run_body(input string tag, input int rl, input int nr, input int stall_after);
    load_filters();
    fork
      drive_pixels(rl * nr);
      collect(stall_after);
    join
    check({tag, "_done_seen"}, done_seen, 1);
    check({tag, "_done_latency"}, done_cyc - hs_cyc, 1);
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_out%0d", tag, i), got_q[i], exp_q[i]);
    @(negedge clk);
    check({tag, "_done_pulse_end"}, done, 0);
  endtask

  task automatic set_ones(input int rl, input int nr);
    for (int b = 0; b < K * K; b++) coef_beats[b] = {N_CH{8'h01}};
    pix_beats.delete();
    for (int i = 0; i < rl * nr; i++) pix_beats.push_back({N_CH{8'h01}});
    exp_q.delete();
    for (int i = 0; i < (rl - K + 1) * (nr - K + 1); i++) exp_q.push_back(18);
  endtask

  task automatic set_ramp_centre();
    for (int b = 0; b < K * K; b++) coef_beats[b] = (b == 4) ? {N_CH{8'h01}} : '0;
    pix_beats.delete();
    for (int i = 0; i < 20; i++) pix_beats.push_back(BW'(i));
    exp_q = '{6, 7, 8, 11, 12, 13};
  endtask

  initial begin
    rst            = 1'b0;
    cfg_row_length = '0;
    cfg_num_rows   = '0;
    start          = 1'b0;
    filt_valid     = 1'b0;
    filt_data      = '0;
    pix_valid      = 1'b0;
    pix_data       = '0;
    out_ready      = 1'b1;

    #2;
    check_quiet("reset");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;

    // Rejected configurations: row too short, row too long, too few rows.
    pulse_start(2, 4);
    check("err_short_cfg_err", cfg_err, 1);
    check("err_short_busy", busy, 0);
    @(negedge clk);
    check("err_short_pulse_end", cfg_err, 0);
    pulse_start(ROW_MAX + 1, 4);
    check("err_long_cfg_err", cfg_err, 1);
    pulse_start(5, 2);
    check("err_rows_cfg_err", cfg_err, 1);
    check("err_rows_busy", busy, 0);

    // All-ones frame, with a bad start issued mid-frame that must be ignored.
    set_ones(5, 4);
    pulse_start(5, 4);
    check("ones_busy", busy, 1);
    check("ones_filt_ready", filt_ready, 1);
    pulse_start(2, 4);
    check("busy_start_cfg_err", cfg_err, 0);
    check("busy_start_filt_ready", filt_ready, 1);
    run_body("ones", 5, 4, -1);

    set_ramp_centre();
    pulse_start(5, 4);
    run_body("ramp", 5, 4, -1);

    set_ramp_centre();
    pulse_start(5, 4);
    run_body("stall", 5, 4, 2);
    check("stall_observed", stall_hits >= 5, 1);

    for (int b = 0; b < K * K; b++) coef_beats[b] = {N_CH{8'h01}};
    pix_beats.delete();
    for (int i = 0; i < 20; i++) pix_beats.push_back({BW{1'b1}});
    exp_q.delete();
`ifdef CONV_ARRAY_RELU_EN
    for (int i = 0; i < 6; i++) exp_q.push_back(0);
`else
    for (int i = 0; i < 6; i++) exp_q.push_back(-18);
`endif
    pulse_start(5, 4);
    run_body("neg", 5, 4, -1);

    // Smallest legal frame: a single window.
    set_ones(3, 3);
    pulse_start(3, 3);
    run_body("min", 3, 3, -1);

    // Abort a frame after 7 pixels, then rerun the all-ones frame.
    set_ones(5, 4);
    pulse_start(5, 4);
    load_filters();
    drive_pixels(7);
    rst = 1'b0;
    #2;
    check_quiet("midreset");
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("midreset_idle_busy", busy, 0);
    check("midreset_no_done", done, 0);
    pulse_start(5, 4);
    run_body("rerun", 5, 4, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/conv_array.md
CONV_ARRAY -- requirements
Module: conv_array

Interface
REQ-001 Parameter N_CH, default 8: input channels, one PE each.
REQ-002 Parameter DATA_W, default 8: signed pixel/coefficient width.
REQ-003 Parameter K, default 3: square kernel size (K x K).
REQ-004 Parameter ROW_MAX, default 256: maximum row length in pixels.
REQ-005 Parameter ACC_W, default 2*DATA_W+$clog2(K*K*N_CH): output sum width.
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-low.
REQ-008 cfg_row_length  in  $clog2(ROW_MAX+1)  pixels per row, sampled at start.
REQ-009 cfg_num_rows  in  16  rows per frame, sampled at start.
REQ-010 start  in  1  one-cycle frame start pulse.
REQ-011 busy  out  1  high from accepted start to done.
REQ-012 done  out  1  one-cycle pulse after last output handshake.
REQ-013 cfg_err  out  1  one-cycle pulse on rejected start.
REQ-014 filt_valid / filt_ready  in / out  1  filter beat handshake.
REQ-015 filt_data  in  N_CH*DATA_W  one coefficient per channel per beat, row-major kernel order.
REQ-016 pix_valid / pix_ready  in / out  1  pixel beat handshake.
REQ-017 pix_data  in  N_CH*DATA_W  one pixel per channel per beat, raster order.
REQ-018 out_valid / out_ready  out / in  1  result handshake.
REQ-019 out_data  out  ACC_W  signed sum over all channels of K x K MAC.

Function
REQ-020 FSM states IDLE, LOAD_FILT, FILL, RUN, DRAIN; IDLE on reset.
REQ-021 IDLE->LOAD_FILT on start when K <= cfg_row_length <= ROW_MAX and cfg_num_rows >= K; otherwise stay IDLE and pulse cfg_err next cycle.
REQ-022 LOAD_FILT: filt_ready=1, accept exactly K*K beats, then FILL; filt_ready=0 in all other states.
REQ-023 FILL: accept pixels, no outputs, until (K-1)*row_length+(K-1) pixels accepted, then RUN.
REQ-024 RUN: one output per accepted pixel whose column >= K-1 (row >= K-1 guaranteed); pixels at column < K-1 produce no output.
REQ-025 Total outputs per frame = (row_length-K+1)*(num_rows-K+1); total pixels = row_length*num_rows.
REQ-026 After last pixel accepted, DRAIN until pipeline empty and last output handshaken, pulse done, return IDLE.
REQ-027 Pixel accept = pix_valid & pix_ready; pix_ready = (FILL|RUN) & (!out_valid | out_ready); whole pipeline stalls on backpressure.
REQ-028 Latency: out_valid asserts exactly 2 cycles after accepting the producing pixel when unstalled (MAC stage, adder-tree stage).
REQ-029 out_data, out_valid held stable while out_valid & !out_ready.
REQ-030 Arithmetic signed, full precision, no saturation within ACC_W.
REQ-031 Column/row counters wrap column at row_length-1 to 0, incrementing row.
REQ-032 start while busy ignored, no cfg_err.
REQ-033 Filter coefficients retained across frames; every frame reloads them.

Reset
REQ-034 rst low: state IDLE, counters 0, line buffers/pipeline cleared, all outputs 0 (busy, done, cfg_err, filt_ready, pix_ready, out_valid, out_data).
REQ-035 rst mid-frame discards partial frame; no done pulse.

Configuration
REQ-036 CONV_ARRAY_RELU_EN defined: out_data = max(sum,0) at adder-tree stage; latency unchanged.
REQ-037 CONV_ARRAY_RELU_EN undefined: out_data is raw signed sum.

Structure
REQ-038 Shared header conv_pkg.vh holds FSM state encodings and default N_CH/DATA_W/K/ROW_MAX values.
REQ-039 One sub-module convolver_ch per channel: K-1 row line buffers of depth ROW_MAX, K x K window, coefficient store, registered MAC; generated N_CH times.
REQ-040 conv_array holds FSM, counters, handshakes, registered adder tree.

Verification
REQ-041 K=3, N_CH=2, row 5, rows 4, all coeffs 1, all pixels 1 -> 6 outputs each 18, done one cycle after last handshake.
REQ-042 Ramp pixels 0..19 ch0, ch1 zero, centre coeff 1 only -> outputs 6,7,8,11,12,13.
REQ-043 out_ready low 10 cycles mid-frame -> out_data stable, pix_ready 0, no lost/duplicated outputs.
REQ-044 start with cfg_row_length=2 -> cfg_err pulse, busy stays 0; start during busy -> ignored.
REQ-045 Pixels -1, coeffs 1: RELU_EN -> all outputs 0; without -> -18 (N_CH=2).
REQ-046 rst low after 7 pixels, new frame -> IDLE, outputs 0, second frame matches REQ-041.
